ram_cmd_master: RTL and testbench
=================================

RAM_CMD_MASTER -- requirements
Module: ram_cmd_master

Interface
REQ-001 The block SHALL have one clock; reset is synchronous and active-high.
REQ-002 Parameters SHALL be, one per line: name, default, meaning.
- ADDR_SIZE, 8, width of the address and data byte.
- TIMEOUT, 16, maximum number of WAIT cycles for tx_valid on a read.

REQ-003 Ports SHALL be, one per line: name, direction, width, meaning.
- clk, in, 1, rising-edge clock.
- rst, in, 1, synchronous active-high reset.
- req_valid, in, 1, request offered.
- req_ready, out, 1, request accepted when high with req_valid.
- req_wr, in, 1, 1 = write, 0 = read.
- req_addr, in, ADDR_SIZE, target address.
- req_wdata, in, ADDR_SIZE, write byte (ignored on reads).
- din, out, ADDR_SIZE+2, command word to the RAM: {opcode[1:0], payload}.
- rx_valid, out, 1, din valid (one-cycle pulse per word).
- tx_valid, in, 1, RAM read data valid.
- dout, in, ADDR_SIZE, RAM read data.
- rsp_valid, out, 1, one-cycle completion pulse.
- rsp_rdata, out, ADDR_SIZE, read result.
- rsp_err, out, 1, read timed out (valid with rsp_valid).
- busy, out, 1, high in every state except IDLE.

Function
REQ-004 The FSM SHALL have the states IDLE, ADDR, DATA, WAIT and RESP, and all outputs SHALL be registered.
REQ-005 req_ready SHALL be 1 only in IDLE; a handshake SHALL latch req_wr, req_addr and req_wdata and move the FSM to ADDR.
REQ-006 In ADDR, din SHALL be {00, addr} for a write or {10, addr} for a read, with rx_valid=1 for exactly one cycle, and the FSM SHALL then move to DATA.
REQ-007 In DATA, din SHALL be {01, wdata} for a write or {11, 8'h00} for a read, with rx_valid=1 for one cycle.
REQ-008 After DATA, a write SHALL move to RESP and a read SHALL move to WAIT with the wait counter cleared.
REQ-009 In WAIT, if tx_valid=1 the block SHALL capture dout into rsp_rdata, set rsp_err=0 and move to RESP.
REQ-010 In WAIT, if tx_valid has not been seen after TIMEOUT cycles, the block SHALL set rsp_rdata=0, set rsp_err=1 and move to RESP; the counter SHALL be $clog2(TIMEOUT+1) bits and SHALL never wrap.
REQ-011 RESP SHALL drive rsp_valid=1 for one cycle and then return to IDLE; responses SHALL have no backpressure.
REQ-012 Write completion SHALL set rsp_err=0 and leave rsp_rdata unchanged.
REQ-013 Latency from handshake at cycle 0 SHALL be: rx_valid at cycles 1 and 2; write rsp_valid at cycle 3; read rsp_valid at cycle k+1 when tx_valid arrives at cycle k≥3.
REQ-014 tx_valid seen outside WAIT SHALL be ignored and SHALL have no effect on state or outputs.
REQ-015 In all other states, rx_valid SHALL be 0 and din SHALL hold its last value.
REQ-016 req_valid while busy SHALL be ignored; the request is not lost if the requester holds it.

Reset
REQ-017 On rst=1 at a clock edge, the block SHALL enter IDLE with din=0, rx_valid=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, busy=0, req_ready=1 on the next cycle.
REQ-018 Reset mid-transaction SHALL abort it with no rsp_valid issued; rst SHALL take priority over all other inputs.

Structure
REQ-019 The opcode constants (WR_ADDR=2'b00, WR_DATA=2'b01, RD_ADDR=2'b10, RD_DATA=2'b11) and the state enum SHALL live in RAM_shared_pkg.
REQ-020 The block SHALL be a single module with no sub-module; the FSM and timeout counter SHALL be inline.

Verification
REQ-021 Write addr=8'h3C, data=8'hA5 -> din=10'h03C at cycle 1, din=10'h1A5 at cycle 2, rsp_valid at cycle 3 with rsp_err=0.
REQ-022 Read addr=8'h3C with the RAM model returning 8'hA5 one cycle after the RD_DATA word -> din=10'h23C then 10'h300, rsp_rdata=8'hA5 and rsp_err=0 at cycle 4.
REQ-023 Read with tx_valid never asserted -> rsp_valid at cycle 3+TIMEOUT with rsp_err=1 and rsp_rdata=0, then req_ready=1.
REQ-024 req_valid held high for back-to-back write then read -> second handshake in the cycle after RESP, with no overlap of rx_valid pulses.
REQ-025 rst pulsed in WAIT -> no rsp_valid, all outputs at reset values; a stray tx_valid in IDLE produces no response.

Source files
------------

// File: rtl/ram_cmd_master_pkg.sv
// Shared definitions for the RAM command master: command opcodes and FSM states.
package RAM_shared_pkg;

    localparam logic [1:0] WR_ADDR = 2'b00;
    localparam logic [1:0] WR_DATA = 2'b01;
    localparam logic [1:0] RD_ADDR = 2'b10;
    localparam logic [1:0] RD_DATA = 2'b11;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        ADDR = 3'd1,
        DATA = 3'd2,
        WAIT = 3'd3,
        RESP = 3'd4
    } state_t;

endpackage

// File: rtl/ram_cmd_master.sv
// Request/response front end that serialises each access into an address word and
// a data word for the RAM, then waits (bounded) for read data before responding.
module ram_cmd_master
    import RAM_shared_pkg::*;
#(
    parameter int ADDR_SIZE = 8,
    parameter int TIMEOUT   = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic                 req_wr,
    input  logic [ADDR_SIZE-1:0] req_addr,
    input  logic [ADDR_SIZE-1:0] req_wdata,
    output logic [ADDR_SIZE+1:0] din,
    output logic                 rx_valid,
    input  logic                 tx_valid,
    input  logic [ADDR_SIZE-1:0] dout,
    output logic                 rsp_valid,
    output logic [ADDR_SIZE-1:0] rsp_rdata,
    output logic                 rsp_err,
    output logic                 busy
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    state_t               state;
    logic                 wr_q;
    logic [ADDR_SIZE-1:0] addr_q;
    logic [ADDR_SIZE-1:0] wdata_q;
    logic [CNT_W-1:0]     wait_cnt;

    // Outputs are updated on the edge that enters a state, so each state's
    // values are visible for exactly the cycle spent in that state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            wr_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            wait_cnt  <= '0;
            din       <= '0;
            rx_valid  <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
            busy      <= 1'b0;
            req_ready <= 1'b1;
        end else begin
            rx_valid  <= 1'b0;
            rsp_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        wr_q      <= req_wr;
                        addr_q    <= req_addr;
                        wdata_q   <= req_wdata;
                        din       <= {(req_wr ? WR_ADDR : RD_ADDR), req_addr};
                        rx_valid  <= 1'b1;
                        req_ready <= 1'b0;
                        busy      <= 1'b1;
                        state     <= ADDR;
                    end
                end
                ADDR: begin
                    din      <= wr_q ? {WR_DATA, wdata_q} : {RD_DATA, {ADDR_SIZE{1'b0}}};
                    rx_valid <= 1'b1;
                    state    <= DATA;
                end
                DATA: begin
                    if (wr_q) begin
                        rsp_valid <= 1'b1;
                        rsp_err   <= 1'b0;
                        state     <= RESP;
                    end else begin
                        wait_cnt <= '0;
                        state    <= WAIT;
                    end
                end
                WAIT: begin
                    if (tx_valid) begin
                        rsp_rdata <= dout;
                        rsp_err   <= 1'b0;
                        rsp_valid <= 1'b1;
                        state     <= RESP;
                    end else if (wait_cnt == CNT_LAST) begin
                        rsp_rdata <= '0;
                        rsp_err   <= 1'b1;
                        rsp_valid <= 1'b1;
                        state     <= RESP;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                RESP: begin
                    req_ready <= 1'b1;
                    busy      <= 1'b0;
                    state     <= IDLE;
                end
                default: begin
                    req_ready <= 1'b1;
                    busy      <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ram_cmd_master.sv
// Randomised and directed check of ram_cmd_master against a per-transaction timeline model.
module tb_ram_cmd_master;

    localparam int AW = 8;
    localparam int TO = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic          req_wr = 1'b0;
    logic [AW-1:0] req_addr = '0;
    logic [AW-1:0] req_wdata = '0;
    logic [AW+1:0] din;
    logic          rx_valid;
    logic          tx_valid = 1'b0;
    logic [AW-1:0] dout = '0;
    logic          rsp_valid;
    logic [AW-1:0] rsp_rdata;
    logic          rsp_err;
    logic          busy;

    int n_checks = 0;
    int n_fail   = 0;
    logic [AW-1:0] model_rdata = '0;

    ram_cmd_master #(.ADDR_SIZE(AW), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_wr(req_wr),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .din(din), .rx_valid(rx_valid), .tx_valid(tx_valid), .dout(dout),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .busy(busy)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset_values();
        chk("rst_din", din, 0);
        chk("rst_rx_valid", rx_valid, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_rdata", rsp_rdata, 0);
        chk("rst_rsp_err", rsp_err, 0);
        chk("rst_busy", busy, 0);
        chk("rst_req_ready", req_ready, 1);
    endtask

    // k = cycle in which tx_valid is driven (cycles counted from the handshake
    // edge); k outside the WAIT window 3..2+TO means the RAM never answers.
    task automatic do_txn(input bit wr, input logic [AW-1:0] addr, input logic [AW-1:0] wdata,
                          input logic [AW-1:0] rdval, input int k, input bit hold,
                          input bit expect_now);
        int waits;
        int r;
        bit exp_err;
        bit answered;
        logic [AW-1:0] new_rdata;
        logic [AW+1:0] addr_word;
        logic [AW+1:0] data_word;
        waits = 0;
        @(negedge clk);
        tx_valid  = 1'b0;
        req_valid = 1'b1;
        req_wr    = wr;
        req_addr  = addr;
        req_wdata = wdata;
        while (!req_ready && waits < 200) begin
            @(negedge clk);
            waits++;
        end
        chk("handshake_ready", req_ready, 1);
        if (expect_now) chk("b2b_immediate", waits, 0);
        if (!req_ready) begin
            req_valid = 1'b0;
            return;
        end
        answered  = !wr && (k >= 3) && (k <= 2 + TO);
        addr_word = {(wr ? 2'b00 : 2'b10), addr};
        data_word = wr ? {2'b01, wdata} : {2'b11, 8'h00};
        if (wr) begin
            r = 3; exp_err = 1'b0; new_rdata = model_rdata;
        end else if (answered) begin
            r = k + 1; exp_err = 1'b0; new_rdata = rdval;
        end else begin
            r = 3 + TO; exp_err = 1'b1; new_rdata = '0;
        end
        @(posedge clk);
        for (int c = 1; c <= r + 1; c++) begin
            #1;
            chk("rx_valid", rx_valid, (c == 1 || c == 2));
            chk("din", din, (c == 1) ? addr_word : data_word);
            chk("rsp_valid", rsp_valid, (c == r));
            chk("busy", busy, (c <= r));
            chk("req_ready", req_ready, (c > r));
            chk("rsp_rdata", rsp_rdata, (c >= r) ? new_rdata : model_rdata);
            if (c == r) chk("rsp_err", rsp_err, exp_err);
            if (c == r + 1) break;
            @(negedge clk);
            if (c == 1 && !hold) req_valid = 1'b0;
            if (answered && c == k) begin
                tx_valid = 1'b1;
                dout     = rdval;
            end else if ((wr || c < 3 || c >= r) && ($urandom_range(0, 3) == 0)) begin
                tx_valid = 1'b1;
                dout     = AW'($urandom);
            end else begin
                tx_valid = 1'b0;
                dout     = AW'($urandom);
            end
            @(posedge clk);
        end
        model_rdata = new_rdata;
    endtask

    initial begin
        bit prev_hold;
        bit hold;
        bit wr;
        repeat (3) @(posedge clk);
        #1;
        chk_reset_values();
        @(negedge clk);
        rst = 1'b0;

        do_txn(1'b1, 8'h3C, 8'hA5, 8'h00, 0, 1'b0, 1'b0);
        do_txn(1'b0, 8'h3C, 8'h00, 8'hA5, 3, 1'b0, 1'b0);
        do_txn(1'b0, 8'h3C, 8'h00, 8'h77, 0, 1'b0, 1'b0);
        do_txn(1'b1, 8'h11, 8'h22, 8'h00, 0, 1'b1, 1'b0);
        do_txn(1'b0, 8'h33, 8'h00, 8'h44, 5, 1'b0, 1'b1);

        // Abort a read while it sits in WAIT, then offer a stray tx_valid in IDLE.
        @(negedge clk);
        tx_valid  = 1'b0;
        req_valid = 1'b1;
        req_wr    = 1'b0;
        req_addr  = 8'h5A;
        chk("abort_ready", req_ready, 1);
        @(negedge clk);
        req_valid = 1'b0;
        repeat (4) @(negedge clk);
        chk("abort_in_wait_busy", busy, 1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk_reset_values();
        @(negedge clk);
        rst      = 1'b0;
        tx_valid = 1'b1;
        dout     = 8'h55;
        model_rdata = '0;
        for (int c = 0; c < 22; c++) begin
            @(posedge clk);
            #1;
            chk("post_rst_rsp_valid", rsp_valid, 0);
            chk("post_rst_busy", busy, 0);
            chk("post_rst_rx_valid", rx_valid, 0);
            @(negedge clk);
            tx_valid = (c < 4);
        end
        chk("post_rst_rdata", rsp_rdata, 0);

        prev_hold = 1'b0;
        for (int i = 0; i < 30; i++) begin
            hold = (i != 29) && ($urandom_range(0, 2) == 0);
            wr   = $urandom_range(0, 1);
            do_txn(wr, AW'($urandom), AW'($urandom), AW'($urandom),
                   $urandom_range(1, 2 + TO + 3), hold, prev_hold);
            prev_hold = hold;
        end

        @(negedge clk);
        req_valid = 1'b0;
        tx_valid  = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
